// File: rtl/worker_batch_sched.sv
// Round-robin batch dispatcher for an array of worker_sram instances.
// Hands out batch indices 0..total-1 one per cycle to free workers and counts completions.
module worker_batch_sched #(
  parameter int unsigned NUM_WORKER = 4,
  parameter int unsigned BATCH_BW   = 8,
  parameter int unsigned WID_BW     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [BATCH_BW:0]            total_batch,
  input  logic [NUM_WORKER-1:0]        batch_finish,
  output logic [NUM_WORKER-1:0]        worker_en,
  output logic [NUM_WORKER-1:0]        worker_rst_n,
  output logic [NUM_WORKER*BATCH_BW-1:0] worker_batch,
  output logic                         busy,
  output logic                         done,
  output logic [BATCH_BW:0]            finished_cnt
);

  localparam int unsigned CNT_W = BATCH_BW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {W_FREE, W_CLR, W_RUN} wstate_t;

  state_t                                  r_state, w_state;
  wstate_t                                 r_wstate [NUM_WORKER];
  wstate_t                                 w_wstate [NUM_WORKER];
  logic [WID_BW-1:0]                       r_rr_ptr, w_rr_ptr;
  logic [CNT_W-1:0]                        r_next_batch, w_next_batch;
  logic [CNT_W-1:0]                        r_total, w_total;
  logic [CNT_W-1:0]                        r_finished_cnt, w_finished_cnt;
  logic [CNT_W-1:0]                        w_pop, w_fin_sum;
  logic [NUM_WORKER-1:0][BATCH_BW-1:0]     r_worker_batch, w_worker_batch;
  logic [NUM_WORKER-1:0]                   r_worker_en, w_worker_en;
  logic [NUM_WORKER-1:0]                   r_worker_rst_n, w_worker_rst_n;
  logic                                    r_busy, w_busy;
  logic                                    r_done, w_done;
  logic [WID_BW-1:0]                       w_idx, w_sel;
  logic                                    w_found;

  // Next-state and next-output logic for the run FSM and every worker slot
  always_comb begin
    w_state        = r_state;
    w_wstate       = r_wstate;
    w_rr_ptr       = r_rr_ptr;
    w_next_batch   = r_next_batch;
    w_total        = r_total;
    w_worker_batch = r_worker_batch;
    w_pop          = '0;
    w_idx          = '0;
    w_sel          = '0;
    w_found        = 1'b0;
    w_worker_en    = '0;
    w_worker_rst_n = '1;

    // Finishes only count for workers actually running
    for (int unsigned i = 0; i < NUM_WORKER; i++) begin
      if (r_wstate[i] == W_RUN && batch_finish[i]) begin
        w_wstate[i] = W_FREE;
        w_pop       = w_pop + CNT_W'(1);
      end else if (r_wstate[i] == W_CLR) begin
        w_wstate[i] = W_RUN;
      end
    end
    w_fin_sum      = r_finished_cnt + w_pop;
    w_finished_cnt = w_fin_sum;

    // First free worker at or after the round-robin pointer
    for (int unsigned k = 0; k < NUM_WORKER; k++) begin
      w_idx = WID_BW'((32'(r_rr_ptr) + k) % NUM_WORKER);
      if (!w_found && r_wstate[w_idx] == W_FREE) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_total        = total_batch;
          w_next_batch   = '0;
          w_finished_cnt = '0;
          w_state        = (total_batch == '0) ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (w_found) begin
          w_wstate[w_sel]       = W_CLR;
          w_worker_batch[w_sel] = r_next_batch[BATCH_BW-1:0];
          w_next_batch          = r_next_batch + CNT_W'(1);
          w_rr_ptr              = (32'(w_sel) == NUM_WORKER - 1) ? '0 : w_sel + WID_BW'(1);
          if (w_next_batch == r_total) w_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_fin_sum == r_total) w_state = S_DONE;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_WORKER; i++) begin
      w_worker_en[i]    = (w_wstate[i] == W_RUN);
      w_worker_rst_n[i] = (w_wstate[i] != W_CLR);
    end
    w_busy = (w_state == S_DISPATCH) || (w_state == S_DRAIN);
    w_done = (w_state == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      for (int unsigned i = 0; i < NUM_WORKER; i++) r_wstate[i] <= W_FREE;
      r_rr_ptr       <= '0;
      r_next_batch   <= '0;
      r_total        <= '0;
      r_finished_cnt <= '0;
      r_worker_batch <= '0;
      r_worker_en    <= '0;
      r_worker_rst_n <= '1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_wstate       <= w_wstate;
      r_rr_ptr       <= w_rr_ptr;
      r_next_batch   <= w_next_batch;
      r_total        <= w_total;
      r_finished_cnt <= w_finished_cnt;
      r_worker_batch <= w_worker_batch;
      r_worker_en    <= w_worker_en;
      r_worker_rst_n <= w_worker_rst_n;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  assign worker_en    = r_worker_en;
  assign worker_rst_n = r_worker_rst_n;
  assign worker_batch = r_worker_batch;
  assign busy         = r_busy;
  assign done         = r_done;
  assign finished_cnt = r_finished_cnt;

endmodule

// File: tb/tb_worker_batch_sched.sv
// Directed bench for worker_batch_sched: hand-timed finish pulses against hand-computed outputs.
module tb_worker_batch_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  total_batch;
  logic [3:0]  batch_finish;
  logic [3:0]  worker_en;
  logic [3:0]  worker_rst_n;
  logic [31:0] worker_batch;
  logic        busy;
  logic        done;
  logic [8:0]  finished_cnt;

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  worker_batch_sched #(.NUM_WORKER(4), .BATCH_BW(8), .WID_BW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .total_batch  (total_batch),
    .batch_finish (batch_finish),
    .worker_en    (worker_en),
    .worker_rst_n (worker_rst_n),
    .worker_batch (worker_batch),
    .busy         (busy),
    .done         (done),
    .finished_cnt (finished_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  // Start sampled at edge 0 of the run; edge numbering restarts here
  task automatic start_run(input logic [8:0] t);
    total_batch = t;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    ecnt        = 0;
  endtask

  // Finish pulse sampled at edge e of the current run
  task automatic fin_at(input int e, input logic [3:0] m);
    run_to(e - 1);
    batch_finish = m;
    tick();
    batch_finish = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; total_batch = '0; batch_finish = '0;
    tick(); tick();
    chk("rst_en",    worker_en,    4'h0);
    chk("rst_rstn",  worker_rst_n, 4'hF);
    chk("rst_batch", worker_batch, 32'h0);
    chk("rst_busy",  busy,         1'b0);
    chk("rst_done",  done,         1'b0);
    chk("rst_cnt",   finished_cnt, 9'd0);
    rst_n = 1'b1;
    tick();

    // Run of 6 with finishes 20 cycles after each enable
    start_run(9'd6);
    chk("t1_busy",   busy,         1'b1);
    chk("t1_rstn0",  worker_rst_n, 4'hF);
    run_to(1);
    chk("t1_clr0",   worker_rst_n, 4'b1110);
    chk("t1_en0",    worker_en,    4'b0000);
    run_to(2);
    chk("t1_en1",    worker_en,    4'b0001);
    chk("t1_clr1",   worker_rst_n, 4'b1101);
    run_to(4);
    chk("t1_batch",  worker_batch, 32'h03020100);
    chk("t1_clr3",   worker_rst_n, 4'b0111);
    run_to(5);
    chk("t1_enall",  worker_en,    4'b1111);
    fin_at(22, 4'b0001);
    chk("t1_f0_en",  worker_en,    4'b1110);
    chk("t1_f0_cnt", finished_cnt, 9'd1);
    fin_at(23, 4'b0010);
    chk("t1_b4",     worker_batch, 32'h03020104);
    chk("t1_b4_clr", worker_rst_n, 4'b1110);
    chk("t1_b4_en",  worker_en,    4'b1100);
    chk("t1_f1_cnt", finished_cnt, 9'd2);
    fin_at(24, 4'b0100);
    chk("t1_b5",     worker_batch, 32'h03020504);
    chk("t1_b5_clr", worker_rst_n, 4'b1101);
    chk("t1_b5_en",  worker_en,    4'b1001);
    chk("t1_drain",  busy,         1'b1);
    fin_at(25, 4'b1000);
    chk("t1_f3_cnt", finished_cnt, 9'd4);
    chk("t1_f3_en",  worker_en,    4'b0011);
    fin_at(44, 4'b0001);
    chk("t1_f4_cnt", finished_cnt, 9'd5);
    chk("t1_f4_dn",  done,         1'b0);
    fin_at(45, 4'b0010);
    chk("t1_done",   done,         1'b1);
    chk("t1_nbusy",  busy,         1'b0);
    chk("t1_cnt6",   finished_cnt, 9'd6);
    chk("t1_en_off", worker_en,    4'h0);
    tick();
    chk("t1_pulse",  done,         1'b0);
    chk("t1_hold",   finished_cnt, 9'd6);

    // Empty run
    start_run(9'd0);
    chk("t2_done",   done,         1'b1);
    chk("t2_busy",   busy,         1'b0);
    chk("t2_cnt",    finished_cnt, 9'd0);
    chk("t2_en",     worker_en,    4'h0);
    chk("t2_rstn",   worker_rst_n, 4'hF);
    tick();
    chk("t2_pulse",  done,         1'b0);
    chk("t2_rstn2",  worker_rst_n, 4'hF);

    // rr_ptr is 2: batches 0..3 go to workers 2,3,0,1
    start_run(9'd6);
    run_to(5);
    chk("t3_batch",  worker_batch, 32'h01000302);
    chk("t3_enall",  worker_en,    4'b1111);
    fin_at(10, 4'b0110);
    chk("t3_cnt2",   finished_cnt, 9'd2);
    chk("t3_en",     worker_en,    4'b1001);
    tick();
    chk("t3_w2clr",  worker_rst_n, 4'b1011);
    chk("t3_w2b4",   worker_batch, 32'h01040302);
    tick();
    chk("t3_w1clr",  worker_rst_n, 4'b1101);
    chk("t3_w1b5",   worker_batch, 32'h01040502);

    // Start during drain must be ignored
    total_batch = 9'd9;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    chk("t4_busy",   busy,         1'b1);
    chk("t4_cnt",    finished_cnt, 9'd2);
    fin_at(20, 4'b1111);
    chk("t4_done",   done,         1'b1);
    chk("t4_cnt6",   finished_cnt, 9'd6);
    tick();
    chk("t4_idle",   busy,         1'b0);

    // Spurious finish from free worker 3 while worker 2 runs batch 0
    start_run(9'd1);
    run_to(1);
    chk("t5_clr",    worker_rst_n, 4'b1011);
    fin_at(3, 4'b1000);
    chk("t5_cnt",    finished_cnt, 9'd0);
    chk("t5_en",     worker_en,    4'b0100);
    chk("t5_busy",   busy,         1'b1);
    chk("t5_ndone",  done,         1'b0);
    fin_at(5, 4'b0100);
    chk("t5_done",   done,         1'b1);
    chk("t5_cnt1",   finished_cnt, 9'd1);
    chk("t5_batch",  worker_batch, 32'h01000502);
    tick();

    // Reset mid-dispatch, then a clean run of 4
    start_run(9'd8);
    run_to(3);
    chk("t6_pre_en", worker_en,    4'b1001);
    rst_n = 1'b0;
    #1;
    chk("t6_en",     worker_en,    4'h0);
    chk("t6_rstn",   worker_rst_n, 4'hF);
    chk("t6_batch",  worker_batch, 32'h0);
    chk("t6_busy",   busy,         1'b0);
    chk("t6_done",   done,         1'b0);
    chk("t6_cnt",    finished_cnt, 9'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_run(9'd4);
    run_to(4);
    chk("t6_batch4", worker_batch, 32'h03020100);
    chk("t6_clr3",   worker_rst_n, 4'b0111);
    chk("t6_drain",  busy,         1'b1);
    run_to(5);
    chk("t6_enall",  worker_en,    4'hF);
    fin_at(10, 4'b1111);
    chk("t6_cnt4",   finished_cnt, 9'd4);
    chk("t6_done4",  done,         1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
